// File: rtl/pesto_vec_pkg.sv
// Shared types and default widths for the vector pair reader.
package pesto_vec_pkg;

    localparam int VALUE_WIDTH       = 16;
    localparam int ADDRESS_WIDTH     = 10;
    localparam int STALL_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vpr_pair_fifo.sv
// Two-entry FIFO holding {last, val1, val2}; head is presented directly.
module vpr_pair_fifo #(
    parameter int width = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [1:0]       count,
    output logic [width-1:0] head
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [width-1:0] entry_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign valid = (count_reg != 2'd0);
    assign count = count_reg;
    assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

endmodule

// File: rtl/vector_pair_reader.sv
// Streams element pairs from two store ports into a 2-deep output FIFO.
// Optional VECTOR_READER_STALL_CNT_EN adds the o_stall_count output.
module vector_pair_reader
    import pesto_vec_pkg::*;
#(
    parameter int value_width   = VALUE_WIDTH,
    parameter int address_width = ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [address_width-1:0] cmd_base1,
    input  logic [address_width-1:0] cmd_base2,
    input  logic [address_width:0]   cmd_len,
    output logic                     mem_wr_en,
    output logic [address_width-1:0] mem_address1,
    output logic [address_width-1:0] mem_address2,
    input  logic [value_width-1:0]   mem_read_val1,
    input  logic [value_width-1:0]   mem_read_val2,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [value_width-1:0]   o_val1,
    output logic [value_width-1:0]   o_val2,
    output logic                     o_last,
    output logic                     o_done
`ifdef VECTOR_READER_STALL_CNT_EN
    ,
    output logic [STALL_COUNT_WIDTH-1:0] o_stall_count
`endif
);

    localparam int FIFO_WIDTH = 2 * value_width + 1;
    localparam logic [address_width:0]   LEN_ONE  = (address_width + 1)'(1);
    localparam logic [address_width-1:0] ADDR_ONE = address_width'(1);

    state_t                   state_reg;
    logic [address_width-1:0] addr1_reg;
    logic [address_width-1:0] addr2_reg;
    logic [address_width:0]   remaining_reg;
    logic                     inflight_reg;
    logic                     inflight_last_reg;
    logic                     cmd_ready_reg;
    logic                     zero_done_reg;

    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [FIFO_WIDTH-1:0] fifo_head;
    logic                  head_last;
    logic                  pop;
    logic                  issue;
    logic                  accept;
    logic                  done_accept;
    logic [1:0]            held_after_pop;

    assign head_last   = fifo_head[FIFO_WIDTH-1];
    assign pop         = fifo_valid && o_ready;
    assign accept      = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
    assign done_accept = (state_reg == DRAIN) && pop && head_last;

    // Credit check counts the slot freed by this cycle's pop so a steady
    // o_ready keeps one pair per cycle flowing.
    assign held_after_pop = fifo_count - {1'b0, pop};
    assign issue = (state_reg == ISSUE) &&
                   ((held_after_pop + {1'b0, inflight_reg}) < 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            addr1_reg         <= '0;
            addr2_reg         <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            cmd_ready_reg     <= 1'b0;
            zero_done_reg     <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (remaining_reg == LEN_ONE);
            zero_done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (accept) begin
                        if (cmd_len != '0) begin
                            addr1_reg     <= cmd_base1;
                            addr2_reg     <= cmd_base2;
                            remaining_reg <= cmd_len;
                            state_reg     <= ISSUE;
                            cmd_ready_reg <= 1'b0;
                        end else begin
                            zero_done_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr1_reg     <= addr1_reg + ADDR_ONE;
                        addr2_reg     <= addr2_reg + ADDR_ONE;
                        remaining_reg <= remaining_reg - LEN_ONE;
                        if (remaining_reg == LEN_ONE) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_accept) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    vpr_pair_fifo #(
        .width(FIFO_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_reg),
        .push_data({inflight_last_reg, mem_read_val1, mem_read_val2}),
        .pop      (pop),
        .valid    (fifo_valid),
        .count    (fifo_count),
        .head     (fifo_head)
    );

`ifdef VECTOR_READER_STALL_CNT_EN
    logic [STALL_COUNT_WIDTH-1:0] stall_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (accept) begin
            stall_count_reg <= '0;
        end else if (fifo_valid && !o_ready && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + STALL_COUNT_WIDTH'(1);
        end
    end

    assign o_stall_count = stall_count_reg;
`endif

    assign cmd_ready    = cmd_ready_reg;
    assign mem_wr_en    = 1'b0;
    assign mem_address1 = addr1_reg;
    assign mem_address2 = addr2_reg;
    assign o_valid      = fifo_valid;
    assign o_val1       = fifo_head[2*value_width-1:value_width];
    assign o_val2       = fifo_head[value_width-1:0];
    assign o_last       = fifo_valid && head_last;
    assign o_done       = zero_done_reg || done_accept;

endmodule

// File: tb/tb_vector_pair_reader.sv
// Scoreboard bench for vector_pair_reader; stimulus queues expected pairs,
// a negedge monitor pops and compares every accepted output pair.
module tb_vector_pair_reader;

    localparam int VW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base1;
    logic [AW-1:0] cmd_base2;
    logic [AW:0]   cmd_len;
    logic          mem_wr_en;
    logic [AW-1:0] mem_address1;
    logic [AW-1:0] mem_address2;
    logic [VW-1:0] mem_read_val1;
    logic [VW-1:0] mem_read_val2;
    logic          o_valid;
    logic          o_ready;
    logic [VW-1:0] o_val1;
    logic [VW-1:0] o_val2;
    logic          o_last;
    logic          o_done;
`ifdef VECTOR_READER_STALL_CNT_EN
    logic [15:0]   o_stall_count;
`endif

    typedef struct packed {
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        logic          last;
    } pair_t;

    pair_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    vector_pair_reader #(
        .value_width  (VW),
        .address_width(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base1    (cmd_base1),
        .cmd_base2    (cmd_base2),
        .cmd_len      (cmd_len),
        .mem_wr_en    (mem_wr_en),
        .mem_address1 (mem_address1),
        .mem_address2 (mem_address2),
        .mem_read_val1(mem_read_val1),
        .mem_read_val2(mem_read_val2),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_val1       (o_val1),
        .o_val2       (o_val2),
        .o_last       (o_last),
        .o_done       (o_done)
`ifdef VECTOR_READER_STALL_CNT_EN
        ,
        .o_stall_count(o_stall_count)
`endif
    );

    // Store contents are a fixed function of address, shared by both ports.
    function automatic logic [VW-1:0] mval(input logic [AW-1:0] a);
        logic [VW-1:0] wide;
        wide = {6'd0, a};
        return 16'hA5A5 ^ (wide * 16'd41);
    endfunction

    always_ff @(posedge clk) begin
        mem_read_val1 <= mval(mem_address1);
        mem_read_val2 <= mval(mem_address2);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each accepted pair and output stability while stalled.
    initial begin : monitor
        pair_t         e;
        logic          stalled_prev;
        logic [33:0]   held;
        stalled_prev = 1'b0;
        held         = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check("stall_hold", 64'({o_valid, o_last, o_val1, o_val2}), 64'(held));
                end
                if (o_valid && o_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pair actual=%0h/%0h required=none", o_val1, o_val2);
                    end else begin
                        e = exp_q.pop_front();
                        $display("pair v1=%h v2=%h last=%0d done=%0d", o_val1, o_val2, o_last, o_done);
                        check("val1", 64'(o_val1), 64'(e.v1));
                        check("val2", 64'(o_val2), 64'(e.v2));
                        check("last", 64'(o_last), 64'(e.last));
                        check("done_on_last", 64'(o_done), 64'(e.last));
                    end
                end
                stalled_prev = o_valid && !o_ready;
                held         = {o_valid, o_last, o_val1, o_val2};
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input int len);
        int    n;
        pair_t e;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        end
        for (int i = 0; i < len; i++) begin
            e.v1   = mval(b1 + AW'(i));
            e.v2   = mval(b2 + AW'(i));
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        $display("cmd base1=%0d base2=%0d len=%0d", b1, b2, len);
        cmd_base1 = b1;
        cmd_base2 = b2;
        cmd_len   = (AW + 1)'(len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in cycle 0 after acceptance; returns the cycle of o_done.
    task automatic wait_done(input int budget, input logic toggle,
                             output int done_cycle, output int first_valid);
        done_cycle  = -1;
        first_valid = -1;
        o_ready     = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_valid && first_valid < 0) begin
                first_valid = c;
            end
            if (o_done) begin
                done_cycle = c;
                break;
            end
            @(posedge clk);
            #1;
            o_ready = toggle ? ((c + 1) % 2 == 0) : 1'b1;
        end
        if (done_cycle < 0) begin
            check("done_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic done_pulse_ends();
        tick();
        o_ready = 1'b1;
        @(negedge clk);
        check("done_pulse_width", 64'(o_done), 64'(0));
    endtask

    initial begin : stimulus
        int dc;
        int fv;
        int seen;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_base1 = '0;
        cmd_base2 = '0;
        cmd_len   = '0;
        o_ready   = 1'b1;

        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_outputs", 64'({o_valid, o_last, o_done, mem_wr_en}), 64'(0));
        check("rst_vals", 64'({o_val1, o_val2}), 64'(0));
        check("rst_addrs", 64'({mem_address1, mem_address2}), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'(1));

        // Basic streaming with o_ready held high.
        send_cmd(10'd0, 10'd100, 4);
        wait_done(100, 1'b0, dc, fv);
        check("len4_first_valid", 64'(fv), 64'(2));
        check("len4_done_cycle", 64'(dc), 64'(5));
        done_pulse_ends();

        // Port-1 address wraps 1022, 1023, 0.
        send_cmd(10'd1022, 10'd7, 3);
        wait_done(100, 1'b0, dc, fv);
        check("wrap_first_valid", 64'(fv), 64'(2));
        check("wrap_done_cycle", 64'(dc), 64'(4));
        done_pulse_ends();

        // Zero-length command.
        send_cmd(10'd50, 10'd60, 0);
        wait_done(20, 1'b0, dc, fv);
        check("len0_done_cycle", 64'(dc), 64'(0));
        check("len0_no_valid", 64'(fv), 64'(-1));
        done_pulse_ends();
        check("len0_ready", 64'(cmd_ready), 64'(1));

        // Consumer toggling ready every cycle.
        send_cmd(10'd200, 10'd300, 8);
        wait_done(200, 1'b1, dc, fv);
        check("toggle_first_valid", 64'(fv), 64'(2));
        check("toggle_done_cycle", 64'(dc), 64'(16));
`ifdef VECTOR_READER_STALL_CNT_EN
        check("stall_count", 64'(o_stall_count), 64'(7));
`endif
        done_pulse_ends();

        // Reset after three of eight pairs.
        send_cmd(10'd400, 10'd500, 8);
        o_ready = 1'b1;
        seen    = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge clk);
            if (o_valid && o_ready) begin
                seen++;
            end
        end
        check("pairs_before_reset", 64'(seen), 64'(3));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_outputs", 64'({o_valid, o_last, o_done, cmd_ready}), 64'(0));
        check("midrst_vals", 64'({o_val1, o_val2}), 64'(0));
        check("midrst_addrs", 64'({mem_address1, mem_address2}), 64'(0));
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        send_cmd(10'd33, 10'd44, 2);
        wait_done(100, 1'b0, dc, fv);
        check("post_rst_first_valid", 64'(fv), 64'(2));
        check("post_rst_done_cycle", 64'(dc), 64'(3));
        done_pulse_ends();

        // Full-depth command.
        send_cmd(10'd5, 10'd600, 1024);
        wait_done(3000, 1'b0, dc, fv);
        check("len1024_done_cycle", 64'(dc), 64'(1025));
        done_pulse_ends();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("mem_wr_en_low", 64'(mem_wr_en), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
